// File: rtl/rx_pkt_supervisor.sv
// Per-packet supervisor for the dot11 receive chain: tracks preamble, header,
// payload bytes and FCS, classifies the outcome and pulses receiver_rst on aborts.
module rx_pkt_supervisor #(
    parameter int HDR_TIMEOUT = 400,
    parameter int GAP_TIMEOUT = 2000,
    parameter int RST_CYCLES  = 4,
    parameter int HOLDOFF     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_in_strobe,
    input  logic        long_preamble_detected,
    input  logic        pkt_header_valid_strobe,
    input  logic        pkt_header_valid,
    input  logic [15:0] pkt_len,
    input  logic        byte_out_strobe,
    input  logic        fcs_out_strobe,
    input  logic        fcs_ok,
    input  logic        ext_rst,
    output logic        receiver_rst,
    output logic        busy,
    output logic        pkt_done_stb,
    output logic [2:0]  pkt_status,
    output logic [15:0] ok_count,
    output logic [15:0] err_count
);

    typedef enum logic [2:0] {IDLE, WAIT_HDR, RECV, FLUSH, HOLD} state_t;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_FCS     = 3'd1;
    localparam logic [2:0] ST_HDR_INV = 3'd2;
    localparam logic [2:0] ST_HDR_TO  = 3'd3;
    localparam logic [2:0] ST_GAP_TO  = 3'd4;
    localparam logic [2:0] ST_OVR     = 3'd5;
    localparam logic [2:0] ST_EXT     = 3'd6;

    localparam logic [15:0] HDR_LIM  = 16'(HDR_TIMEOUT);
    localparam logic [15:0] GAP_LIM  = 16'(GAP_TIMEOUT);
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] HOLD_LIM = 16'(HOLDOFF);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx, cnt_inc;
    logic [15:0] byte_cnt, byte_cnt_nx;
    logic [15:0] len_q, len_nx;
    logic        pre_q, pre_rise;
    logic        done_nx, abort;
    logic [2:0]  status_nx, abort_code;

    // One shared counter: samples in WAIT_HDR/RECV/HOLD, clock cycles in FLUSH.
    assign pre_rise = long_preamble_detected && !pre_q;
    assign cnt_inc  = (sample_in_strobe && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;

    assign receiver_rst = (state == FLUSH);
    assign busy         = (state != IDLE);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt_inc;
        byte_cnt_nx = byte_cnt;
        len_nx      = len_q;
        abort       = 1'b0;
        abort_code  = ST_OK;
        done_nx     = 1'b0;
        status_nx   = pkt_status;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (ext_rst) begin
                    state_nx = FLUSH;
                end else if (pre_rise) begin
                    state_nx = WAIT_HDR;
                end
            end
            WAIT_HDR: begin
                if (ext_rst) begin
                    abort      = 1'b1;
                    abort_code = ST_EXT;
                end else if (pkt_header_valid_strobe) begin
                    if (pkt_header_valid) begin
                        state_nx    = RECV;
                        len_nx      = pkt_len;
                        byte_cnt_nx = '0;
                        cnt_nx      = '0;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ST_HDR_INV;
                    end
                end else if (cnt_inc >= HDR_LIM) begin
                    abort      = 1'b1;
                    abort_code = ST_HDR_TO;
                end
            end
            RECV: begin
                if (ext_rst) begin
                    abort      = 1'b1;
                    abort_code = ST_EXT;
                end else if (fcs_out_strobe) begin
                    state_nx  = IDLE;
                    cnt_nx    = '0;
                    done_nx   = 1'b1;
                    status_nx = fcs_ok ? ST_OK : ST_FCS;
                end else if (byte_out_strobe) begin
                    if (byte_cnt >= len_q) begin
                        abort      = 1'b1;
                        abort_code = ST_OVR;
                    end else begin
                        byte_cnt_nx = byte_cnt + 16'd1;
                        cnt_nx      = '0;
                    end
                end else if (cnt_inc >= GAP_LIM) begin
                    abort      = 1'b1;
                    abort_code = ST_GAP_TO;
                end
            end
            FLUSH: begin
                if (ext_rst) begin
                    cnt_nx = '0;
                end else if (cnt >= RST_LAST) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            HOLD: begin
                if (ext_rst) begin
                    state_nx = FLUSH;
                    cnt_nx   = '0;
                end else if (cnt_inc >= HOLD_LIM) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (abort) begin
            state_nx  = FLUSH;
            cnt_nx    = '0;
            done_nx   = 1'b1;
            status_nx = abort_code;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            byte_cnt     <= '0;
            len_q        <= '0;
            pre_q        <= 1'b0;
            pkt_done_stb <= 1'b0;
            pkt_status   <= ST_OK;
            ok_count     <= '0;
            err_count    <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            byte_cnt     <= byte_cnt_nx;
            len_q        <= len_nx;
            pre_q        <= long_preamble_detected;
            pkt_done_stb <= done_nx;
            pkt_status   <= status_nx;
            if (done_nx) begin
                if (status_nx == ST_OK) begin
                    if (ok_count != 16'hFFFF) ok_count <= ok_count + 16'd1;
                end else if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_pkt_supervisor.sv
// Testbench for rx_pkt_supervisor: packet table, corner sequences and
// randomized packets checked against an outcome-level model.
module tb_rx_pkt_supervisor;

    localparam int HDR_T  = 400;
    localparam int GAP_T  = 2000;
    localparam int RST_C  = 4;
    localparam int HOLD_N = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sample_in_strobe = 1'b0;
    logic        long_preamble_detected = 1'b0;
    logic        pkt_header_valid_strobe = 1'b0;
    logic        pkt_header_valid = 1'b0;
    logic [15:0] pkt_len = '0;
    logic        byte_out_strobe = 1'b0;
    logic        fcs_out_strobe = 1'b0;
    logic        fcs_ok = 1'b0;
    logic        ext_rst = 1'b0;
    logic        receiver_rst;
    logic        busy;
    logic        pkt_done_stb;
    logic [2:0]  pkt_status;
    logic [15:0] ok_count;
    logic [15:0] err_count;

    rx_pkt_supervisor #(
        .HDR_TIMEOUT(HDR_T),
        .GAP_TIMEOUT(GAP_T),
        .RST_CYCLES(RST_C),
        .HOLDOFF(HOLD_N)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sample_in_strobe(sample_in_strobe),
        .long_preamble_detected(long_preamble_detected),
        .pkt_header_valid_strobe(pkt_header_valid_strobe),
        .pkt_header_valid(pkt_header_valid),
        .pkt_len(pkt_len),
        .byte_out_strobe(byte_out_strobe),
        .fcs_out_strobe(fcs_out_strobe),
        .fcs_ok(fcs_ok),
        .ext_rst(ext_rst),
        .receiver_rst(receiver_rst),
        .busy(busy),
        .pkt_done_stb(pkt_done_stb),
        .pkt_status(pkt_status),
        .ok_count(ok_count),
        .err_count(err_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int ok_m = 0;
    int err_m = 0;

    int   done_n = 0;
    int   rst_rise = 0;
    int   rst_hi = 0;
    int   last_st = 0;
    logic rst_d = 1'b0;

    always @(negedge clock) begin
        if (pkt_done_stb) begin
            done_n  <= done_n + 1;
            last_st <= int'(pkt_status);
        end
        if (receiver_rst) rst_hi <= rst_hi + 1;
        if (receiver_rst && !rst_d) rst_rise <= rst_rise + 1;
        rst_d <= receiver_rst;
    end

    typedef struct {
        int hv;
        int hd;
        int len;
        int nb;
        int gap;
        int fok;
        int ext;
        int sdiv;
        int bwf;
        int exp;
    } pkt_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic s);
        sample_in_strobe = s;
        @(posedge clock);
        #1;
        sample_in_strobe        = 1'b0;
        pkt_header_valid_strobe = 1'b0;
        byte_out_strobe         = 1'b0;
        fcs_out_strobe          = 1'b0;
        ext_rst                 = 1'b0;
    endtask

    task automatic samples(input int n, input int sdiv);
        for (int i = 0; i < n; i++) begin
            for (int k = 1; k < sdiv; k++) cyc(1'b0);
            cyc(1'b1);
        end
    endtask

    task automatic tally(input int st);
        if (st == 0) begin
            if (ok_m < 65535) ok_m++;
        end else if (err_m < 65535) begin
            err_m++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            cyc(1'b1);
            n++;
        end
        chk({tag, " idle"}, int'(busy), 0);
    endtask

    // Outcome of a packet from its description, in order of occurrence in time.
    function automatic int predict(input pkt_t p);
        if (p.hd >= HDR_T) return 3;
        if (p.ext == 1) return 6;
        if (p.hv == 0) return 2;
        if (p.gap >= GAP_T) return 4;
        if (p.nb > p.len) return 5;
        if (p.ext == 2) return 6;
        return (p.fok != 0) ? 0 : 1;
    endfunction

    task automatic run_pkt(input pkt_t p, input int expst, input string tag);
        int d0, r0, h0, ab;
        d0 = done_n;
        r0 = rst_rise;
        h0 = rst_hi;
        long_preamble_detected = 1'b1;
        cyc(1'b0);
        long_preamble_detected = 1'b0;
        cyc(1'b0);
        samples(p.hd, p.sdiv);
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid        = (p.hv != 0);
        pkt_len                 = 16'(p.len);
        ext_rst                 = (p.ext == 1);
        cyc(1'b0);
        for (int i = 0; i < p.nb; i++) begin
            samples(p.gap, p.sdiv);
            byte_out_strobe = 1'b1;
            cyc(1'b0);
        end
        samples(p.gap, p.sdiv);
        fcs_out_strobe  = 1'b1;
        fcs_ok          = (p.fok != 0);
        ext_rst         = (p.ext == 2);
        byte_out_strobe = (p.bwf != 0);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        wait_idle(tag);
        tally(expst);
        ab = (expst >= 2) ? 1 : 0;
        chk({tag, " done_count"}, done_n - d0, 1);
        chk({tag, " status"}, last_st, expst);
        chk({tag, " ok_count"}, int'(ok_count), ok_m);
        chk({tag, " err_count"}, int'(err_count), err_m);
        chk({tag, " rst_pulses"}, rst_rise - r0, ab);
        chk({tag, " rst_cycles"}, rst_hi - h0, ab * RST_C);
    endtask

    pkt_t tbl[15];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, h0, hi;
        pkt_t p;

        //      hv  hd   len  nb   gap   fok ext sdiv bwf exp
        tbl[0]  = '{1, 10,  100, 100, 50,   1,  0,  1,   0,  0};
        tbl[1]  = '{1, 10,  100, 100, 50,   0,  0,  1,   0,  1};
        tbl[2]  = '{0, 7,   20,  3,   4,    1,  0,  2,   0,  2};
        tbl[3]  = '{1, 400, 5,   0,   3,    1,  0,  1,   0,  3};
        tbl[4]  = '{1, 399, 0,   0,   3,    1,  0,  1,   0,  0};
        tbl[5]  = '{1, 5,   5,   1,   2000, 1,  0,  1,   0,  4};
        tbl[6]  = '{1, 5,   2,   2,   1999, 1,  0,  1,   0,  0};
        tbl[7]  = '{1, 5,   10,  11,  3,    1,  0,  1,   0,  5};
        tbl[8]  = '{1, 5,   10,  10,  3,    1,  0,  2,   0,  0};
        tbl[9]  = '{1, 5,   0,   1,   2,    1,  0,  1,   0,  5};
        tbl[10] = '{1, 5,   10,  4,   3,    1,  2,  1,   0,  6};
        tbl[11] = '{1, 5,   10,  4,   3,    1,  1,  1,   0,  6};
        tbl[12] = '{0, 5,   10,  4,   3,    1,  1,  1,   0,  6};
        tbl[13] = '{1, 5,   3,   3,   3,    0,  0,  3,   0,  1};
        tbl[14] = '{1, 5,   2,   2,   3,    1,  0,  1,   1,  0};

        reset = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        chk("reset receiver_rst", int'(receiver_rst), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(pkt_done_stb), 0);
        chk("reset status", int'(pkt_status), 0);
        chk("reset ok_count", int'(ok_count), 0);
        chk("reset err_count", int'(err_count), 0);
        reset = 1'b0;
        cyc(1'b0);

        for (int i = 0; i < 15; i++) begin
            run_pkt(tbl[i], tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Invalid header: exact flush length, holdoff, preamble ignored in HOLD.
        long_preamble_detected = 1'b1;
        cyc(1'b0);
        long_preamble_detected = 1'b0;
        cyc(1'b0);
        samples(3, 1);
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid        = 1'b0;
        cyc(1'b0);
        tally(2);
        chk("inv done", int'(pkt_done_stb), 1);
        chk("inv status", int'(pkt_status), 2);
        chk("inv rst_rise", int'(receiver_rst), 1);
        hi = 1;
        for (int i = 0; i < RST_C; i++) begin
            cyc(1'b1);
            hi += int'(receiver_rst);
        end
        chk("inv rst_len", hi, RST_C);
        chk("inv rst_low", int'(receiver_rst), 0);
        long_preamble_detected = 1'b1;
        for (int i = 0; i < HOLD_N - 1; i++) cyc(1'b1);
        chk("inv hold_busy", int'(busy), 1);
        cyc(1'b1);
        chk("inv hold_end", int'(busy), 0);
        cyc(1'b1);
        cyc(1'b1);
        chk("inv pre_in_hold", int'(busy), 0);
        chk("inv status_held", int'(pkt_status), 2);
        chk("inv err_count", int'(err_count), err_m);
        long_preamble_detected = 1'b0;
        cyc(1'b0);

        // Header timeout counts sample strobes, not clocks.
        d0 = done_n;
        long_preamble_detected = 1'b1;
        cyc(1'b0);
        long_preamble_detected = 1'b0;
        cyc(1'b0);
        samples(HDR_T - 1, 2);
        cyc(1'b0);
        chk("hto early", done_n - d0, 0);
        chk("hto busy", int'(busy), 1);
        cyc(1'b1);
        tally(3);
        chk("hto done", int'(pkt_done_stb), 1);
        chk("hto status", int'(pkt_status), 3);
        chk("hto rst", int'(receiver_rst), 1);
        wait_idle("hto");
        chk("hto err_count", int'(err_count), err_m);

        // External reset in IDLE, retriggered during FLUSH.
        d0 = done_n;
        r0 = rst_rise;
        h0 = rst_hi;
        ext_rst = 1'b1;
        cyc(1'b0);
        chk("xidle rst", int'(receiver_rst), 1);
        chk("xidle busy", int'(busy), 1);
        chk("xidle done", int'(pkt_done_stb), 0);
        cyc(1'b0);
        ext_rst = 1'b1;
        cyc(1'b0);
        wait_idle("xidle");
        chk("xidle done_count", done_n - d0, 0);
        chk("xidle pulses", rst_rise - r0, 1);
        chk("xidle rst_cycles", rst_hi - h0, RST_C + 2);
        chk("xidle ok_count", int'(ok_count), ok_m);
        chk("xidle err_count", int'(err_count), err_m);
        chk("xidle status", int'(pkt_status), 3);

        // Reset while receiving payload.
        d0 = done_n;
        r0 = rst_rise;
        long_preamble_detected = 1'b1;
        cyc(1'b0);
        long_preamble_detected = 1'b0;
        cyc(1'b0);
        samples(3, 1);
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid        = 1'b1;
        pkt_len                 = 16'd50;
        cyc(1'b0);
        for (int i = 0; i < 3; i++) begin
            samples(2, 1);
            byte_out_strobe = 1'b1;
            cyc(1'b0);
        end
        chk("mrst recv_busy", int'(busy), 1);
        reset = 1'b1;
        cyc(1'b0);
        chk("mrst receiver_rst", int'(receiver_rst), 0);
        chk("mrst busy", int'(busy), 0);
        chk("mrst done", int'(pkt_done_stb), 0);
        chk("mrst status", int'(pkt_status), 0);
        chk("mrst ok_count", int'(ok_count), 0);
        chk("mrst err_count", int'(err_count), 0);
        reset = 1'b0;
        ok_m  = 0;
        err_m = 0;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        chk("mrst no_done", done_n - d0, 0);
        chk("mrst no_pulse", rst_rise - r0, 0);

        // Randomized packets against the outcome model.
        for (int i = 0; i < 20; i++) begin
            p.hv   = ($urandom_range(9) != 0) ? 1 : 0;
            p.hd   = int'($urandom_range(60, 1));
            p.len  = int'($urandom_range(12));
            p.nb   = int'($urandom_range(14));
            p.gap  = int'($urandom_range(30, 1));
            p.fok  = int'($urandom_range(1));
            p.sdiv = int'($urandom_range(3, 1));
            p.bwf  = int'($urandom_range(1));
            case ($urandom_range(5))
                0: p.ext = 1;
                1: p.ext = (p.hv != 0 && p.nb <= p.len) ? 2 : 0;
                default: p.ext = 0;
            endcase
            p.exp = predict(p);
            run_pkt(p, p.exp, $sformatf("rnd%0d", i));
        end

        // Error counter saturation.
        force dut.err_count = 16'hFFFE;
        cyc(1'b0);
        release dut.err_count;
        cyc(1'b0);
        err_m = 65534;
        chk("sat preset", int'(err_count), err_m);
        run_pkt(tbl[11], 6, "sat1");
        run_pkt(tbl[2], 2, "sat2");
        chk("sat hold", int'(err_count), 65535);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
